// File: rtl/pic_priority_sequencer.sv
// Interrupt priority resolver and INTA acknowledge sequencer for an 8-input PIC.
// Tracks the in-service register, rotating priority and the vector-bus handshake.

module pic_prio_find (
    input  logic [7:0] vec,
    input  logic [2:0] lp,
    output logic       found,
    output logic [2:0] rank,
    output logic [2:0] idx
);
    logic [15:0] dbl;
    logic [7:0]  rot;

    // Rotate so bit 0 holds the highest-priority index (lp+1).
    assign dbl = {vec, vec};
    assign rot = dbl[{1'b0, lp} + 4'd1 +: 8];

    always_comb begin
        rank = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) rank = 3'(i);
    end

    assign found = |vec;
    assign idx   = lp + 3'd1 + rank;
endmodule

module pic_priority_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       inta,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       rotate_on_eoi,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic       ack_valid,
    output logic [2:0] ack_idx,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK1 = 2'd2;
    localparam logic [1:0] S_ACK2 = 2'd3;

    logic [1:0] state;
    logic [2:0] lp;
    logic [2:0] cur_idx;
    logic       spurious;
    logic       inta_q;

    logic [1:0][7:0] fnd_vec;
    logic [1:0]      fnd;
    logic [1:0][2:0] fnd_rank;
    logic [1:0][2:0] fnd_idx;

    // Slot 0 resolves unmasked requests, slot 1 resolves the in-service bits.
    assign fnd_vec[0] = irr & ~imr;
    assign fnd_vec[1] = isr;

    for (genvar g = 0; g < 2; g++) begin : g_find
        pic_prio_find u_find (
            .vec   (fnd_vec[g]),
            .lp    (lp),
            .found (fnd[g]),
            .rank  (fnd_rank[g]),
            .idx   (fnd_idx[g])
        );
    end

    logic       eligible;
    logic [2:0] cand;
    logic       inta_rise;
    logic       inta_fall;

    assign eligible  = fnd[0] && (!fnd[1] || (fnd_rank[0] < fnd_rank[1]));
    assign cand      = fnd_idx[0];
    assign inta_rise = inta & ~inta_q;
    assign inta_fall = ~inta & inta_q;

    logic       take_ack;
    logic [2:0] eoi_tgt;
    logic       eoi_hit;
    logic       aeoi_hit;
    logic [7:0] isr_clr;
    logic [7:0] isr_set;
    logic [7:0] isr_next;
    logic [2:0] lp_next;

    assign take_ack = (state == S_PEND) && inta_rise && eligible;

    // Clears land before the acknowledge set, so a same-cycle set wins.
    always_comb begin
        eoi_tgt  = eoi_specific ? eoi_level : fnd_idx[1];
        eoi_hit  = eoi_valid && isr[eoi_tgt];
        aeoi_hit = (state == S_ACK2) && inta_fall && aeoi && !spurious && isr[cur_idx];
        isr_clr  = 8'h00;
        if (eoi_hit)  isr_clr[eoi_tgt] = 1'b1;
        if (aeoi_hit) isr_clr[cur_idx] = 1'b1;
        isr_set  = take_ack ? (8'h01 << cand) : 8'h00;
        isr_next = (isr & ~isr_clr) | isr_set;
        lp_next  = lp;
        if (rotate_on_eoi) begin
            if (aeoi_hit)     lp_next = cur_idx;
            else if (eoi_hit) lp_next = eoi_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lp        <= 3'd7;
            isr       <= 8'h00;
            int_out   <= 1'b0;
            ack_valid <= 1'b0;
            ack_idx   <= 3'd0;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            cur_idx   <= 3'd0;
            spurious  <= 1'b0;
            inta_q    <= 1'b0;
        end else begin
            inta_q    <= inta;
            isr       <= isr_next;
            lp        <= lp_next;
            ack_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (eligible) begin
                        state   <= S_PEND;
                        int_out <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (inta_rise) begin
                        state <= S_ACK1;
                        if (eligible) begin
                            cur_idx   <= cand;
                            spurious  <= 1'b0;
                            ack_valid <= 1'b1;
                            ack_idx   <= cand;
                        end else begin
                            // Request vanished before INTA: answer with IR7, touch nothing.
                            cur_idx  <= 3'd7;
                            spurious <= 1'b1;
                        end
                    end else if (!eligible) begin
                        state   <= S_IDLE;
                        int_out <= 1'b0;
                    end
                end
                S_ACK1: begin
                    if (inta_rise) begin
                        state    <= S_ACK2;
                        data_out <= {vector_base, cur_idx};
                        data_oe  <= 1'b1;
                    end
                end
                S_ACK2: begin
                    if (inta_fall) begin
                        state    <= S_IDLE;
                        data_out <= 8'h00;
                        data_oe  <= 1'b0;
                        int_out  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pic_priority_sequencer.md
PIC_PRIORITY_SEQUENCER -- requirements
Module: pic_priority_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 `clk` SHALL be an input, 1 bit wide, and is the system clock; all state updates on its rising edge.
REQ-003 `rst` SHALL be an input, 1 bit wide: a synchronous, active-high reset.
REQ-004 `irr` SHALL be an input, 8 bits wide, carrying the pending-request bits from the request register.
REQ-005 `imr` SHALL be an input, 8 bits wide; a 1 masks the corresponding IR.
REQ-006 `inta` SHALL be an input, 1 bit wide: the interrupt-acknowledge level, active-high. It is sampled on `clk`.
REQ-007 `vector_base` SHALL be an input, 5 bits wide, giving vector bits T7..T3.
REQ-008 `aeoi` SHALL be an input, 1 bit wide, selecting automatic end-of-interrupt (EOI).
REQ-009 `rotate_on_eoi` SHALL be an input, 1 bit wide, selecting automatic priority rotation when an ISR bit is cleared.
REQ-010 `eoi_valid`, `eoi_specific` and `eoi_level[2:0]` SHALL be inputs forming the EOI command:
- `eoi_valid` is a one-cycle strobe;
- `eoi_level` is used only when `eoi_specific`=1.
REQ-011 `int_out` SHALL be an output, 1 bit wide, and registered; it is the interrupt request to the CPU.
REQ-012 `ack_valid` SHALL be an output, 1 bit wide: a one-cycle pulse telling the request register to clear `irr[ack_idx]`.
REQ-013 `ack_idx` SHALL be an output, 3 bits wide, giving the index being acknowledged.
REQ-014 `isr` SHALL be an output, 8 bits wide: the in-service register.
REQ-015 `data_out` and `data_oe` SHALL be outputs, 8 bits and 1 bit wide, carrying the vector bus and its drive enable.

Function
REQ-016 The block SHALL keep a lowest-priority pointer `lp[2:0]`; priority runs `lp+1` (highest) through `lp` (lowest), modulo 8.
REQ-017 A candidate SHALL be the highest-priority index `i` with `irr[i] & ~imr[i]`.
REQ-018 The candidate SHALL be eligible only if it has strictly higher priority than every set `isr` bit (fully nested mode).
REQ-019 The block SHALL detect a rising edge of `inta` as `inta`=1 with the previous-cycle `inta`=0, and a falling edge likewise.
REQ-020 The block SHALL implement the states IDLE, PEND, ACK1 and ACK2.
REQ-021 In IDLE, if an eligible candidate exists, the block SHALL go to PEND and set `int_out`=1 on the next edge (1-cycle latency).
REQ-022 In PEND, if no eligible candidate exists and no `inta` rise occurs, the block SHALL clear `int_out` and return to IDLE.
REQ-023 In PEND, on an `inta` rise with an eligible candidate `i`, the block SHALL:
- latch `cur_idx`=`i`;
- set `isr[i]`;
- pulse `ack_valid` with `ack_idx`=`i`;
- go to ACK1.
REQ-024 In PEND, on an `inta` rise with no eligible candidate, the block SHALL latch a spurious IR7 (`cur_idx`=7) with no ISR set and no `ack_valid`, then go to ACK1.
REQ-025 In ACK1, on an `inta` rise, the block SHALL go to ACK2 and drive `data_out`={`vector_base`,`cur_idx`} with `data_oe`=1 while in ACK2.
REQ-026 On an `inta` fall in ACK2, the block SHALL do the following:
- clear `data_oe` and `int_out`;
- if `aeoi`=1 and the acknowledge was not spurious, clear `isr[cur_idx]` (rotating if `rotate_on_eoi`);
- return to IDLE.
REQ-027 A non-specific EOI SHALL clear the highest-priority set `isr` bit; a specific EOI SHALL clear `isr[eoi_level]`.
REQ-028 An EOI when the target bit is already clear SHALL have no effect.
REQ-029 On any ISR clear with `rotate_on_eoi`=1, the block SHALL set `lp` to the cleared index.
REQ-030 When an EOI and an ISR set occur in the same cycle, the block SHALL apply the clear first and then the set, so the set wins on the same bit.
REQ-031 A request that newly becomes eligible while in ACK1 or ACK2 SHALL NOT alter `cur_idx`; it SHALL be served from IDLE afterwards.
REQ-032 Outside ACK2, `data_out` SHALL be 8'h00 and `data_oe` SHALL be 0.

Reset
REQ-033 `rst`=1 SHALL drive the following on the next edge:
- state IDLE;
- `lp`=7;
- `isr`=0;
- `int_out`=0, `ack_valid`=0, `ack_idx`=0;
- `data_out`=0, `data_oe`=0;
- `cur_idx`=0.
REQ-034 A reset mid-acknowledge SHALL abort the sequence without an `ack_valid` pulse.

Verification
REQ-035 Bench scenario, nested acknowledge:
- stimulus: `irr`=8'h24, `imr`=0, `vector_base`=5'h08; two `inta` pulses;
- response: `int_out`=1 one cycle later; `ack_valid` with `ack_idx`=2; `isr`=8'h04; `data_out`=8'h42.
REQ-036 Bench scenario, priority blocked and resumed:
- stimulus: `isr`=8'h04; `irr`=8'h20; then a non-specific EOI;
- response: `int_out` stays 0 until the EOI; then `isr`=0 and `int_out`=1 on the second edge.
REQ-037 Bench scenario, spurious request:
- stimulus: `irr` drops to 0 between PEND and the first `inta`;
- response: vector={`vector_base`,3'b111}; `isr` unchanged; no `ack_valid`.
REQ-038 Bench scenario, automatic EOI with rotation:
- stimulus: `aeoi`=1, `rotate_on_eoi`=1, request on IR3 acknowledged;
- response: after the `inta` fall, `isr`=0 and `lp`=3; a following `irr`=8'h18 acknowledges IR4 first.
REQ-039 Bench scenario, reset mid-acknowledge:
- stimulus: `rst` asserted in ACK2;
- response: `data_oe`=0, `isr`=0, `int_out`=0 and state IDLE on the next edge.
